paddle_array: RTL and testbench

PADDLE_ARRAY -- requirements
Module: paddle_array

---
 rtl/paddle_array.sv | 156 +++++++++++++++
 tb/tb_paddle_array.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/paddle_array.sv
// -----------------------------------------------------------------------------
// paddle_array
//
// A row of independent paddles. Each paddle has a left-edge position that
// moves left or right on movement ticks while a key is held. Holding the same
// direction accelerates from a slow step to a fast step after ACCEL_TICKS
// ticks. The position is clamped to the legal field range.
//
// Ports
//   clock          : single clock, all state on the rising edge
//   reset          : asynchronous, active-low reset
//   tick           : one-cycle movement strobe; nothing changes without it
//   key_left[i]    : paddle i move-left request (level)
//   key_right[i]   : paddle i move-right request (level)
//   paddle_left    : registered left edges, paddle i at [i*POS_W +: POS_W]
//   paddle_centre  : left + PADDLE_LEN/2 - 1, same packing (combinational)
//   moving[i]      : 1 when paddle i moved on the last tick (registered)
//   at_limit[i]    : 1 when paddle i sits at 0 or FIELD_MAX-PADDLE_LEN
//   state_dbg      : FSM state of paddle i at [2*i +: 2]
//                    (0 = IDLE, 1 = SLOW, 2 = FAST)
//
// Handshake: there is no valid/ready pair here. tick acts as a one-cycle
// qualifier; keys are sampled only on rising edges where tick is 1.
// -----------------------------------------------------------------------------
module paddle_array #(
    parameter int NUM_PADDLES = 2,
    parameter int POS_W       = 8,
    parameter int PADDLE_LEN  = 40,
    parameter int FIELD_MAX   = 240,
    parameter int INIT_LEFT   = 100,
    parameter int SLOW_STEP   = 1,
    parameter int FAST_STEP   = 4,
    parameter int ACCEL_TICKS = 8
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           tick,
    input  logic [NUM_PADDLES-1:0]         key_left,
    input  logic [NUM_PADDLES-1:0]         key_right,
    output logic [NUM_PADDLES*POS_W-1:0]   paddle_left,
    output logic [NUM_PADDLES*POS_W-1:0]   paddle_centre,
    output logic [NUM_PADDLES-1:0]         moving,
    output logic [NUM_PADDLES-1:0]         at_limit,
    output logic [NUM_PADDLES*2-1:0]       state_dbg
);

    // Parameter legality, reported at elaboration.
    if (!(PADDLE_LEN <= FIELD_MAX && FIELD_MAX < (1 << POS_W))) begin : g_bad_field
        $error("paddle_array: require PADDLE_LEN <= FIELD_MAX < 2**POS_W");
    end
    if (!(FAST_STEP >= SLOW_STEP && SLOW_STEP >= 1)) begin : g_bad_step
        $error("paddle_array: require FAST_STEP >= SLOW_STEP >= 1");
    end

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SLOW = 2'd1,
        ST_FAST = 2'd2
    } state_t;

    localparam int CNT_W = $clog2(ACCEL_TICKS + 1);
    // Two extra bits: one for the carry past 2^POS_W-1, one for the sign
    // when stepping below zero. Clamping happens in this wider domain.
    localparam int EXT_W = POS_W + 2;

    localparam logic [POS_W-1:0] MAX_LEFT    = POS_W'(FIELD_MAX - PADDLE_LEN);
    localparam logic [POS_W-1:0] RESET_LEFT  = POS_W'(INIT_LEFT);
    localparam logic [POS_W-1:0] CENTRE_OFS  = POS_W'(PADDLE_LEN / 2 - 1);
    localparam logic [POS_W-1:0] SLOW_W      = POS_W'(SLOW_STEP);
    localparam logic [POS_W-1:0] FAST_W      = POS_W'(FAST_STEP);
    localparam logic [CNT_W-1:0] ACCEL_W     = CNT_W'(ACCEL_TICKS);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    for (genvar i = 0; i < NUM_PADDLES; i++) begin : g_paddle
        state_t             state_q, state_d;
        logic               dir_q, dir_d;      // 1 = right, 0 = left
        logic [CNT_W-1:0]   cnt_q, cnt_d;
        logic [POS_W-1:0]   left_q, left_d;
        logic               moving_q;
        logic               req_l, req_r, req_any;
        logic [POS_W-1:0]   step;
        logic signed [EXT_W-1:0] pos_ext, step_ext, sum, max_ext;

        // Both keys pressed cancel out to NONE.
        assign req_l   = key_left[i]  & ~key_right[i];
        assign req_r   = key_right[i] & ~key_left[i];
        assign req_any = req_l | req_r;

        // State register; every register is gated by tick.
        always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
                state_q  <= ST_IDLE;
                dir_q    <= 1'b0;
                cnt_q    <= '0;
                left_q   <= RESET_LEFT;
                moving_q <= 1'b0;
            end else if (tick) begin
                state_q  <= state_d;
                dir_q    <= dir_d;
                cnt_q    <= cnt_d;
                left_q   <= left_d;
                moving_q <= (left_d != left_q);
            end
        end

        // Next-state logic. A limit hit does not touch state or counter.
        always_comb begin
            state_d = state_q;
            dir_d   = dir_q;
            cnt_d   = cnt_q;
            if (!req_any) begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end else if (state_q == ST_IDLE || dir_q != req_r) begin
                // Fresh press or reversal restarts acceleration.
                state_d = ST_SLOW;
                dir_d   = req_r;
                cnt_d   = CNT_ONE;
            end else if (state_q == ST_SLOW && cnt_q < ACCEL_W) begin
                cnt_d   = cnt_q + CNT_ONE;
            end else begin
                // Counter has reached ACCEL_TICKS and stays there.
                state_d = ST_FAST;
            end
        end

        // Output logic: step size from the state being entered, then the
        // clamped next position.
        always_comb begin
            step = '0;
            if (req_any) begin
                step = (state_d == ST_FAST) ? FAST_W : SLOW_W;
            end
            pos_ext  = $signed({2'b00, left_q});
            step_ext = $signed({2'b00, step});
            max_ext  = $signed({2'b00, MAX_LEFT});
            sum      = dir_d ? (pos_ext + step_ext) : (pos_ext - step_ext);
            if (!req_any) begin
                left_d = left_q;
            end else if (sum < 0) begin
                left_d = '0;
            end else if (sum > max_ext) begin
                left_d = MAX_LEFT;
            end else begin
                left_d = sum[POS_W-1:0];
            end
        end

        assign paddle_left[i*POS_W +: POS_W]   = left_q;
        assign paddle_centre[i*POS_W +: POS_W] = left_q + CENTRE_OFS;
        assign moving[i]                       = moving_q;
        assign at_limit[i]                     = (left_q == '0) || (left_q == MAX_LEFT);
        assign state_dbg[2*i +: 2]             = state_q;
    end

endmodule

// File: tb/tb_paddle_array.sv
// -----------------------------------------------------------------------------
// tb_paddle_array
//
// Self-checking bench for paddle_array with default parameters. A run-length
// reference model tracks, per paddle, the position and how many consecutive
// ticks the current direction has been held; step size follows from that
// count (the first ACCEL_TICKS held ticks are slow, later ones fast).
// -----------------------------------------------------------------------------
module tb_paddle_array;

    localparam int NP    = 2;
    localparam int PW    = 8;
    localparam int PLEN  = 40;
    localparam int FMAX  = 240;
    localparam int INIT  = 100;
    localparam int SLOW  = 1;
    localparam int FAST  = 4;
    localparam int ACCEL = 8;
    localparam int MAXL  = FMAX - PLEN;

    logic               clock;
    logic               reset;
    logic               tick;
    logic [NP-1:0]      key_left;
    logic [NP-1:0]      key_right;
    logic [NP*PW-1:0]   paddle_left;
    logic [NP*PW-1:0]   paddle_centre;
    logic [NP-1:0]      moving;
    logic [NP-1:0]      at_limit;
    logic [NP*2-1:0]    state_dbg;

    paddle_array #(
        .NUM_PADDLES(NP), .POS_W(PW), .PADDLE_LEN(PLEN), .FIELD_MAX(FMAX),
        .INIT_LEFT(INIT), .SLOW_STEP(SLOW), .FAST_STEP(FAST), .ACCEL_TICKS(ACCEL)
    ) dut (
        .clock(clock), .reset(reset), .tick(tick),
        .key_left(key_left), .key_right(key_right),
        .paddle_left(paddle_left), .paddle_centre(paddle_centre),
        .moving(moving), .at_limit(at_limit), .state_dbg(state_dbg)
    );

    // ---------------- clock / reset ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ---------------- reference model ----------------
    int   m_pos  [NP];
    int   m_held [NP];   // consecutive same-direction ticks, 0 when idle
    int   m_dir  [NP];   // +1 right, -1 left
    logic m_mov  [NP];

    int tests = 0;
    int fails = 0;
    logic [NP*PW-1:0] exp_q[$];

    function automatic void model_reset();
        for (int i = 0; i < NP; i++) begin
            m_pos[i]  = INIT;
            m_held[i] = 0;
            m_dir[i]  = 0;
            m_mov[i]  = 1'b0;
        end
    endfunction

    function automatic void model_tick(input logic [NP-1:0] kl, input logic [NP-1:0] kr);
        for (int i = 0; i < NP; i++) begin
            int old_pos, d, np;
            old_pos = m_pos[i];
            if (kl[i] == kr[i]) begin
                m_held[i] = 0;
            end else begin
                d = kr[i] ? 1 : -1;
                if (m_held[i] > 0 && m_dir[i] == d) m_held[i]++;
                else begin
                    m_held[i] = 1;
                    m_dir[i]  = d;
                end
                np = old_pos + d * ((m_held[i] > ACCEL) ? FAST : SLOW);
                if (np < 0) np = 0;
                if (np > MAXL) np = MAXL;
                m_pos[i] = np;
            end
            m_mov[i] = (m_pos[i] != old_pos);
        end
    endfunction

    function automatic int model_state(input int i);
        if (m_held[i] == 0) return 0;
        if (m_held[i] <= ACCEL) return 1;
        return 2;
    endfunction

    function automatic logic [NP*PW-1:0] model_left_bus();
        logic [NP*PW-1:0] v;
        for (int i = 0; i < NP; i++) v[i*PW +: PW] = PW'(m_pos[i]);
        return v;
    endfunction

    // ---------------- scoreboard ----------------
    task automatic check_val(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_outputs(input string tag);
        logic [NP*PW-1:0] exp_bus;
        exp_bus = exp_q.pop_front();
        check_val({tag, " left_bus"}, int'(paddle_left), int'(exp_bus));
        for (int i = 0; i < NP; i++) begin
            check_val($sformatf("%s centre%0d", tag, i), int'(paddle_centre[i*PW +: PW]),
                      (m_pos[i] + PLEN / 2 - 1) % 256);
            check_val($sformatf("%s moving%0d", tag, i), int'(moving[i]), int'(m_mov[i]));
            check_val($sformatf("%s at_limit%0d", tag, i), int'(at_limit[i]),
                      (m_pos[i] == 0 || m_pos[i] == MAXL) ? 1 : 0);
            check_val($sformatf("%s state%0d", tag, i), int'(state_dbg[2*i +: 2]), model_state(i));
        end
    endtask

    // ---------------- driver ----------------
    task automatic drive(input logic [NP-1:0] kl, input logic [NP-1:0] kr,
                         input logic tk, input string tag);
        @(negedge clock);
        key_left  = kl;
        key_right = kr;
        tick      = tk;
        if (tk) model_tick(kl, kr);
        exp_q.push_back(model_left_bus());
        @(posedge clock);
        #1;
        tick = 1'b0;
        check_outputs(tag);
    endtask

    typedef struct {
        logic [NP-1:0] kl;
        logic [NP-1:0] kr;
        int            exp0;
        int            exp1;
    } vec_t;

    vec_t vecs[10];
    int   accel_exp[10] = '{101, 102, 103, 104, 105, 106, 107, 108, 112, 116};

    initial begin
        logic [NP-1:0] kl, kr;

        for (int k = 0; k < 10; k++) begin
            vecs[k].kl   = 2'b00;
            vecs[k].kr   = 2'b01;
            vecs[k].exp0 = accel_exp[k];
            vecs[k].exp1 = INIT;
        end

        // Reset state
        reset = 1'b0; tick = 1'b0; key_left = '0; key_right = '0;
        model_reset();
        repeat (3) @(posedge clock);
        #1;
        check_val("reset left0",   int'(paddle_left[0 +: PW]), 100);
        check_val("reset left1",   int'(paddle_left[PW +: PW]), 100);
        check_val("reset centre0", int'(paddle_centre[0 +: PW]), 119);
        check_val("reset centre1", int'(paddle_centre[PW +: PW]), 119);
        check_val("reset moving",  int'(moving), 0);
        check_val("reset at_limit", int'(at_limit), 0);
        @(negedge clock);
        reset = 1'b1;

        // Acceleration table
        for (int k = 0; k < 10; k++) begin
            drive(vecs[k].kl, vecs[k].kr, 1'b1, $sformatf("accel%0d", k));
            check_val($sformatf("accel%0d left0", k), int'(paddle_left[0 +: PW]), vecs[k].exp0);
            check_val($sformatf("accel%0d left1", k), int'(paddle_left[PW +: PW]), vecs[k].exp1);
        end

        // Reversal from FAST: one pixel the other way
        drive(2'b01, 2'b00, 1'b1, "reverse");
        check_val("reverse left0", int'(paddle_left[0 +: PW]), 115);

        // Both keys: no motion, IDLE
        drive(2'b01, 2'b01, 1'b1, "conflict");
        check_val("conflict left0", int'(paddle_left[0 +: PW]), 115);
        check_val("conflict state0", int'(state_dbg[1:0]), 0);

        // Keys without tick change nothing
        drive(2'b01, 2'b10, 1'b0, "notick");
        check_val("notick left0", int'(paddle_left[0 +: PW]), 115);

        // Left clamp
        for (int k = 0; k < 40; k++) drive(2'b01, 2'b00, 1'b1, "lclamp");
        check_val("lclamp left0", int'(paddle_left[0 +: PW]), 0);
        check_val("lclamp moving0", int'(moving[0]), 0);
        check_val("lclamp at_limit0", int'(at_limit[0]), 1);
        check_val("lclamp state0", int'(state_dbg[1:0]), 2);

        // Right clamp on paddle 1
        for (int k = 0; k < 40; k++) drive(2'b00, 2'b10, 1'b1, "rclamp");
        check_val("rclamp left1", int'(paddle_left[PW +: PW]), 200);
        check_val("rclamp centre1", int'(paddle_centre[PW +: PW]), 219);
        check_val("rclamp at_limit1", int'(at_limit[1]), 1);

        // Async reset while in FAST
        drive(2'b00, 2'b00, 1'b1, "pre_ar");
        for (int k = 0; k < 9; k++) drive(2'b00, 2'b01, 1'b1, "ar_accel");
        check_val("ar fast state0", int'(state_dbg[1:0]), 2);
        @(negedge clock);
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        exp_q.push_back(model_left_bus());
        check_outputs("async_rst");
        key_right = 2'b01; tick = 1'b1;
        @(posedge clock);
        #1;
        tick = 1'b0;
        exp_q.push_back(model_left_bus());
        check_outputs("rst_held");
        @(negedge clock);
        reset = 1'b1;
        drive(2'b00, 2'b01, 1'b1, "post_rst");
        check_val("post_rst left0", int'(paddle_left[0 +: PW]), 101);
        check_val("post_rst state0", int'(state_dbg[1:0]), 1);

        // Randomized traffic against the model; keys tend to persist
        kl = '0; kr = '0;
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 3) == 0) kl = NP'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) kr = NP'($urandom_range(0, 3));
            drive(kl, kr, ($urandom_range(0, 7) != 0), "rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
